gate_bist_checker: RTL and testbench
====================================

# gate_bist_checker

Synthesizable built-in self-test engine for the 2-input gate library. It drives all four input combinations into a gate under test, samples the gate output after a programmable settle interval, and compares each sample against the expected truth table of the selected function. It reports a mismatch count, a pass flag and the first failing vector. It sits beside the gate instances as their hardware stimulus/response counterpart and covers the response-checking end that an open-loop stimulus bench lacks.

## Interface
- SETTLE_CYCLES, 2: extra cycles each vector is held before its sample; legal range 0..255.
- ERR_W, 3: width of err_count; minimum 3.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset. One clock, `clk`; reset is asynchronous and active-low on `rst_n`.
- start  in  1  single-cycle run request; honoured only in IDLE.
- func_sel  in  3  expected function, latched at start: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 BUF(a), 111 NOT(a).
- gate_a  out  1  stimulus to gate input a.
- gate_b  out  1  stimulus to gate input b.
- gate_y  in  1  output of the gate under test.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  err_count==0 for the last completed run; held until the next start.
- err_count  out  ERR_W  mismatches in the last or current run; saturates at all-ones.
- first_fail_vec  out  2  {a,b} of the first mismatch.
- first_fail_valid  out  1  first_fail_vec holds a captured mismatch.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- IDLE: gate_a=gate_b=0, busy=0. When start=1, latch func_sel, clear err_count, first_fail_*, and pass, set vec=00, clear hold counter, and go to DRIVE.
- DRIVE: {gate_a,gate_b}=vec and busy=1. The hold counter counts 0..SETTLE_CYCLES.
  - At the edge where counter==SETTLE_CYCLES, sample gate_y and compare it with expected(func, vec).
  - On a mismatch, err_count increments (saturating). If first_fail_valid=0, capture vec and set first_fail_valid.
  - If vec==11, go to DONE. Otherwise vec increments and the counter clears.
- Vector order is fixed: 00, 01, 10, 11 (a=vec[1], b=vec[0]).
- DONE: lasts one cycle. done=1, busy=0, pass=(err_count==0), including any mismatch from the final sample. Then return to IDLE.
- start while busy: ignored, with no effect on the current run.
- start during the DONE cycle: ignored. A new run requires start in IDLE.
- func_sel changes after the start edge: ignored until the next start.
- Reset (asserted at any time, including mid-run): state returns to IDLE immediately, and all outputs take their reset values. No partial results are retained.

## Timing
- Reset values: gate_a=0, gate_b=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=00, first_fail_valid=0.
- Each vector is held for SETTLE_CYCLES+1 cycles. gate_y is sampled at the last rising edge of the hold, so the gate has SETTLE_CYCLES+1 cycles to settle.
- Cycle 0 is the edge where start is sampled.
  - busy rises after edge 0 and stays high for exactly 4*(SETTLE_CYCLES+1) cycles.
  - done is high in the single cycle after busy falls, i.e. during cycle 4*(SETTLE_CYCLES+1)+1.
- pass, err_count and first_fail_* are stable and valid in the done cycle, and hold until the next accepted start.
- err_count updates at the sample edge, so the bench sees the new value in the following cycle.

## Test plan
- Correct NAND connected, func_sel=010, SETTLE_CYCLES=2, pulse start: vectors 00,01,10,11 each held 3 cycles. done in cycle 13, pass=1, err_count=0, first_fail_valid=0.
- gate_y tied to 1, func_sel=010: err_count=1, first_fail_vec=11, first_fail_valid=1, pass=0.
- gate_y tied to 0, func_sel=010: err_count=3, first_fail_vec=00, pass=0. Follow with a correct NAND and a second start: pass=1, err_count=0, first_fail_valid=0.
- SETTLE_CYCLES=0, correct XOR, func_sel=100: busy high exactly 4 cycles, done in cycle 5, pass=1. Repeat with func_sel=111 against a NOT(a) model: pass=1.
- With the correct NAND, start again in cycles 3 and 7 while busy: run length, done timing and results are identical to the first scenario.
- Assert rst_n low in cycle 6 of a run: immediately busy=0, gate_a=gate_b=0, err_count=0, and no done pulse. After release, a fresh start completes normally.

Source files
------------

// File: rtl/gate_bist_checker_if.sv
// Signal bundle between the BIST checker and its host/gate-under-test side.
// The checker uses the slave modport; the host drives start/func_sel and
// returns the gate output on gate_y.
interface gate_bist_checker_if #(
  parameter int ERR_W = 3
);
  logic             start;
  logic [2:0]       func_sel;
  logic             gate_a;
  logic             gate_b;
  logic             gate_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       first_fail_vec;
  logic             first_fail_valid;

  modport master (
    output start, func_sel, gate_y,
    input  gate_a, gate_b, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );

  modport slave (
    input  start, func_sel, gate_y,
    output gate_a, gate_b, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/gate_bist_checker.sv
// Built-in self-test engine for 2-input gates: walks vectors 00,01,10,11,
// holds each for SETTLE_CYCLES+1 cycles, samples gate_y on the last edge of
// the hold and compares it against the truth table selected at start.
//
// state | meaning
// IDLE  | waiting for start, stimulus parked at 00
// DRIVE | applying vec, counting the settle interval, sampling
// DONE  | one-cycle completion pulse, results valid
module gate_bist_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  gate_bist_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(SETTLE_CYCLES);

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       func_q;
  logic [1:0]       vec_q;
  logic [7:0]       hold_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_inc;
  logic [1:0]       ffv_q;
  logic             ffvalid_q;
  logic             pass_q;
  logic             sample;
  logic             mismatch;
  logic             expected;
  logic             vec_a;
  logic             vec_b;

  assign vec_a    = vec_q[1];
  assign vec_b    = vec_q[0];
  assign sample   = (state == DRIVE) && (hold_q == HOLD_LAST);
  assign mismatch = sample && (bus.gate_y != expected);
  assign err_inc  = (err_q == '1) ? err_q : err_q + ERR_W'(1);

  // Expected gate response for the latched function at the current vector.
  always_comb begin
    expected = 1'b0;
    case (func_q)
      3'b000:  expected = vec_a & vec_b;
      3'b001:  expected = vec_a | vec_b;
      3'b010:  expected = ~(vec_a & vec_b);
      3'b011:  expected = ~(vec_a | vec_b);
      3'b100:  expected = vec_a ^ vec_b;
      3'b101:  expected = ~(vec_a ^ vec_b);
      3'b110:  expected = vec_a;
      default: expected = ~vec_a;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = DRIVE;
      DRIVE:   if (sample && (vec_q == 2'b11)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs: stimulus only leaves 00 while driving.
  always_comb begin
    bus.gate_a = 1'b0;
    bus.gate_b = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      DRIVE: begin
        bus.gate_a = vec_a;
        bus.gate_b = vec_b;
        bus.busy   = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Vector/hold sequencing and result capture; pass folds in the final sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q    <= 3'b000;
      vec_q     <= 2'b00;
      hold_q    <= 8'd0;
      err_q     <= '0;
      ffv_q     <= 2'b00;
      ffvalid_q <= 1'b0;
      pass_q    <= 1'b0;
    end else if ((state == IDLE) && bus.start) begin
      func_q    <= bus.func_sel;
      vec_q     <= 2'b00;
      hold_q    <= 8'd0;
      err_q     <= '0;
      ffv_q     <= 2'b00;
      ffvalid_q <= 1'b0;
      pass_q    <= 1'b0;
    end else if (state == DRIVE) begin
      if (sample) begin
        if (mismatch) begin
          err_q <= err_inc;
          if (!ffvalid_q) begin
            ffv_q     <= vec_q;
            ffvalid_q <= 1'b1;
          end
        end
        if (vec_q == 2'b11) begin
          pass_q <= !mismatch && (err_q == '0);
        end else begin
          vec_q  <= vec_q + 2'd1;
          hold_q <= 8'd0;
        end
      end else begin
        hold_q <= hold_q + 8'd1;
      end
    end
  end

  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_vec   = ffv_q;
  assign bus.first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench for gate_bist_checker: two instances (settle 2 and settle 0) share a
// behavioural gate model; expected results are computed when a run is started
// and pushed to a scoreboard that is popped at the done pulse.
module tb_gate_bist_checker;

  typedef struct {
    logic [2:0] err;
    logic [1:0] ffv;
    logic       ffvalid;
    logic       pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] func = 3'b000;
  logic       sel = 1'b0;
  int         mode = 0;
  logic [2:0] gate_fn = 3'b010;
  int         tests = 0;
  int         fails = 0;
  exp_t       sb[$];

  always #5 clk = ~clk;

  gate_bist_checker_if #(.ERR_W(3)) if0 ();
  gate_bist_checker_if #(.ERR_W(3)) if1 ();

  gate_bist_checker #(.SETTLE_CYCLES(2), .ERR_W(3)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  gate_bist_checker #(.SETTLE_CYCLES(0), .ERR_W(3)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  function automatic logic exp_bit(input logic [2:0] f, input logic a, input logic b);
    logic [3:0] tt;
    case (f)
      3'b000:  tt = 4'b1000;
      3'b001:  tt = 4'b1110;
      3'b010:  tt = 4'b0111;
      3'b011:  tt = 4'b0001;
      3'b100:  tt = 4'b0110;
      3'b101:  tt = 4'b1001;
      3'b110:  tt = 4'b1100;
      default: tt = 4'b0011;
    endcase
    return tt[{a, b}];
  endfunction

  function automatic logic gate_model(input int m, input logic [2:0] gf, input logic a, input logic b);
    if (m == 1) return 1'b1;
    if (m == 2) return 1'b0;
    return exp_bit(gf, a, b);
  endfunction

  assign if0.start    = start && !sel;
  assign if1.start    = start && sel;
  assign if0.func_sel = func;
  assign if1.func_sel = func;
  assign if0.gate_y   = gate_model(mode, gate_fn, if0.gate_a, if0.gate_b);
  assign if1.gate_y   = gate_model(mode, gate_fn, if1.gate_a, if1.gate_b);

  logic       o_busy, o_done, o_a, o_b, o_pass, o_ffvalid;
  logic [2:0] o_err;
  logic [1:0] o_ffv;
  assign o_busy    = sel ? if1.busy : if0.busy;
  assign o_done    = sel ? if1.done : if0.done;
  assign o_a       = sel ? if1.gate_a : if0.gate_a;
  assign o_b       = sel ? if1.gate_b : if0.gate_b;
  assign o_pass    = sel ? if1.pass : if0.pass;
  assign o_ffvalid = sel ? if1.first_fail_valid : if0.first_fail_valid;
  assign o_err     = sel ? if1.err_count : if0.err_count;
  assign o_ffv     = sel ? if1.first_fail_vec : if0.first_fail_vec;

  function automatic exp_t model_run(input logic [2:0] f);
    exp_t       e;
    logic [1:0] v;
    logic       y;
    e.err = 3'd0; e.ffv = 2'b00; e.ffvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      y = gate_model(mode, gate_fn, v[1], v[0]);
      if (y !== exp_bit(f, v[1], v[0])) begin
        if (e.err != 3'd7) e.err = e.err + 3'd1;
        if (!e.ffvalid) begin
          e.ffv = v;
          e.ffvalid = 1'b1;
        end
      end
    end
    e.pass = (e.err == 3'd0);
    return e;
  endfunction

  // Runs one test sequence; st_a/st_b are extra edges on which start is
  // presented (0 = none); chg_func scrambles func_sel after the start edge.
  task automatic run_case(input string name, input logic [2:0] f, input int st_a,
                          input int st_b, input logic chg_func);
    int         s;
    int         len;
    exp_t       e;
    exp_t       got;
    logic [1:0] vexp;
    s   = sel ? 0 : 2;
    len = 4 * (s + 1);
    e   = model_run(f);
    @(negedge clk);
    func  = f;
    start = 1'b1;
    sb.push_back(e);
    for (int k = 0; k <= len + 2; k++) begin
      @(negedge clk);
      start = (k + 1 == st_a) || (k + 1 == st_b);
      if (chg_func) func = ~f;
      vexp = (k < len) ? 2'(k / (s + 1)) : 2'b00;
      tests++;
      if (o_busy !== (k < len)) begin
        fails++;
        $display("FAIL %s busy k=%0d got %b want %b", name, k, o_busy, (k < len));
      end
      tests++;
      if ({o_a, o_b} !== vexp) begin
        fails++;
        $display("FAIL %s vec k=%0d got %b want %b", name, k, {o_a, o_b}, vexp);
      end
      tests++;
      if (o_done !== (k == len)) begin
        fails++;
        $display("FAIL %s done k=%0d got %b want %b", name, k, o_done, (k == len));
      end
      if ((o_done === 1'b1) && (sb.size() != 0)) begin
        got = sb.pop_front();
        tests++;
        if (o_err !== got.err) begin
          fails++;
          $display("FAIL %s err_count got %0d want %0d", name, o_err, got.err);
        end
        tests++;
        if (o_ffvalid !== got.ffvalid) begin
          fails++;
          $display("FAIL %s first_fail_valid got %b want %b", name, o_ffvalid, got.ffvalid);
        end
        tests++;
        if (got.ffvalid && (o_ffv !== got.ffv)) begin
          fails++;
          $display("FAIL %s first_fail_vec got %b want %b", name, o_ffv, got.ffv);
        end
        tests++;
        if (o_pass !== got.pass) begin
          fails++;
          $display("FAIL %s pass got %b want %b", name, o_pass, got.pass);
        end
      end
    end
    start = 1'b0;
    func  = f;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s no done pulse, pending %0d want 0", name, sb.size());
      sb.delete();
    end
    // Results must persist past the done cycle until the next start.
    tests++;
    if (o_pass !== e.pass || o_err !== e.err) begin
      fails++;
      $display("FAIL %s hold pass/err got %b/%0d want %b/%0d", name, o_pass, o_err, e.pass, e.err);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    tests++;
    if ({if0.gate_a, if0.gate_b, if0.busy, if0.done, if0.pass, if0.first_fail_valid} !== 6'b0) begin
      fails++;
      $display("FAIL reset0 ctrl got %b want 000000",
               {if0.gate_a, if0.gate_b, if0.busy, if0.done, if0.pass, if0.first_fail_valid});
    end
    tests++;
    if ({if0.err_count, if0.first_fail_vec} !== 5'b0) begin
      fails++;
      $display("FAIL reset0 data got %b want 00000", {if0.err_count, if0.first_fail_vec});
    end
    tests++;
    if ({if1.gate_a, if1.gate_b, if1.busy, if1.done, if1.pass, if1.first_fail_valid,
         if1.err_count, if1.first_fail_vec} !== 11'b0) begin
      fails++;
      $display("FAIL reset1 outputs got %b want 0", {if1.gate_a, if1.gate_b, if1.busy,
               if1.done, if1.pass, if1.first_fail_valid, if1.err_count, if1.first_fail_vec});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nand_faults;
    sel = 1'b0; gate_fn = 3'b010;
    mode = 0; run_case("nand_ok", 3'b010, 0, 0, 1'b0);
    mode = 1; run_case("nand_tie1", 3'b010, 0, 0, 1'b0);
    mode = 2; run_case("nand_tie0", 3'b010, 0, 0, 1'b0);
    mode = 0; run_case("nand_rerun", 3'b010, 0, 0, 1'b0);
  endtask

  task automatic test_zero_settle;
    sel = 1'b1; mode = 0;
    gate_fn = 3'b100; run_case("xor_s0", 3'b100, 0, 0, 1'b0);
    gate_fn = 3'b111; run_case("not_s0", 3'b111, 0, 0, 1'b0);
    gate_fn = 3'b000; run_case("and_s0", 3'b000, 0, 0, 1'b0);
    mode = 1; gate_fn = 3'b001; run_case("nor_tie1_s0", 3'b011, 0, 0, 1'b0);
    mode = 0;
  endtask

  task automatic test_back_to_back;
    sel = 1'b0; mode = 0; gate_fn = 3'b010;
    run_case("start_busy", 3'b010, 3, 7, 1'b1);
    run_case("start_done", 3'b010, 13, 0, 1'b0);
    gate_fn = 3'b101;
    run_case("xnor_s2", 3'b101, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_run;
    sel = 1'b0; mode = 2; gate_fn = 3'b010;
    @(negedge clk);
    func  = 3'b010;
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    tests++;
    if (o_err !== 3'd1 || o_busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset err/busy got %0d/%b want 1/1", o_err, o_busy);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({o_busy, o_a, o_b, o_done} !== 4'b0) begin
      fails++;
      $display("FAIL mid_reset ctrl got %b want 0000", {o_busy, o_a, o_b, o_done});
    end
    tests++;
    if ({o_err, o_ffvalid, o_pass} !== 5'b0) begin
      fails++;
      $display("FAIL mid_reset results got %b want 00000", {o_err, o_ffvalid, o_pass});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      tests++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
        fails++;
        $display("FAIL post_reset idle k=%0d done/busy got %b/%b want 0/0", k, o_done, o_busy);
      end
    end
    mode = 0;
    run_case("after_reset", 3'b010, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_nand_faults;
    test_zero_settle;
    test_back_to_back;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
